// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory-port arbiter.
package mem_arb_pkg;

    localparam int DefDataWidth  = 16;
    localparam int DefAddrWidth  = 16;
    localparam int DefMemLatency = 2;

    // Latency counter width; covers MemLatency 1..15.
    localparam int CntWidth = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arbState_e;

    typedef enum logic {
        GNT_P = 1'b0,
        GNT_D = 1'b1
    } grant_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: on a tie the requester not granted last wins.
// gnt[0] = processor port, gnt[1] = debug/loader port (one-hot or zero).
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       reqP,
    input  logic       reqD,
    input  grant_e     lastGnt,
    output logic [1:0] gnt
);

    // Pick a single winner; alternate when both ask.
    always_comb begin
        gnt = 2'b00;
        if (reqP && reqD) begin
            gnt = (lastGnt == GNT_D) ? 2'b01 : 2'b10;
        end else if (reqP) begin
            gnt = 2'b01;
        end else if (reqD) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between the processor data port (P)
// and the debug/loader port (D).
//
// Handshake (both requesters): raise Req with Write/Addr/WData stable and
// hold them until Ready. Operands are latched at grant, so changes after the
// grant edge (including dropping Req) do not affect the access in flight.
// Ready is a one-cycle completion pulse; for reads RData is valid from that
// cycle and holds until the next read by the same requester completes.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DataWidth  = DefDataWidth,
    parameter int AddrWidth  = DefAddrWidth,
    parameter int MemLatency = DefMemLatency
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 P_Req,
    input  logic                 P_Write,
    input  logic [AddrWidth-1:0] P_Addr,
    input  logic [DataWidth-1:0] P_WData,
    output logic                 P_Ready,
    output logic [DataWidth-1:0] P_RData,
    output logic                 P_Stall,
    input  logic                 D_Req,
    input  logic                 D_Write,
    input  logic [AddrWidth-1:0] D_Addr,
    input  logic [DataWidth-1:0] D_WData,
    output logic                 D_Ready,
    output logic [DataWidth-1:0] D_RData,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic [AddrWidth-1:0] MemAddr,
    output logic [DataWidth-1:0] MemData,
    input  logic [DataWidth-1:0] MemOutput,
    output logic [1:0]           dbgState
);

    localparam logic [CntWidth-1:0] CntLoad = CntWidth'(MemLatency - 1);

    arbState_e              state;
    arbState_e              nextState;
    logic [CntWidth-1:0]    cnt;
    grant_e                 curGnt;
    grant_e                 lastGnt;
    logic [1:0]             gnt;
    logic [AddrWidth-1:0]   latAddr;
    logic [DataWidth-1:0]   latWData;
    logic                   latWrite;
    logic [DataWidth-1:0]   pRData;
    logic [DataWidth-1:0]   dRData;

    rr_arb2 uArb (
        .reqP    (P_Req),
        .reqD    (D_Req),
        .lastGnt (lastGnt),
        .gnt     (gnt)
    );

    // State register; reset drops any access in flight.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state: grant from IDLE, hold ACCESS for MemLatency cycles, one DONE cycle.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (gnt != 2'b00) nextState = ACCESS;
            ACCESS:  if (cnt == '0)    nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Operand latch at grant, latency countdown, read capture and last-grant update.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt      <= '0;
            curGnt   <= GNT_P;
            lastGnt  <= GNT_D;
            latAddr  <= '0;
            latWData <= '0;
            latWrite <= 1'b0;
            pRData   <= '0;
            dRData   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt != 2'b00) begin
                        cnt      <= CntLoad;
                        curGnt   <= gnt[1] ? GNT_D : GNT_P;
                        latAddr  <= gnt[1] ? D_Addr  : P_Addr;
                        latWData <= gnt[1] ? D_WData : P_WData;
                        latWrite <= gnt[1] ? D_Write : P_Write;
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!latWrite) begin
                        if (curGnt == GNT_P) pRData <= MemOutput;
                        else                 dRData <= MemOutput;
                    end
                end
                DONE: begin
                    lastGnt <= curGnt;
                end
                default: ;
            endcase
        end
    end

    // Memory strobes and completion pulses decoded from state; read/write are exclusive.
    always_comb begin
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemAddr  = '0;
        MemData  = '0;
        if (state == ACCESS) begin
            MemAddr = latAddr;
            if (latWrite) begin
                MemWrite = 1'b1;
                MemData  = latWData;
            end else begin
                MemRead = 1'b1;
            end
        end
        P_Ready = (state == DONE) && (curGnt == GNT_P);
        D_Ready = (state == DONE) && (curGnt == GNT_D);
        P_Stall = P_Req && !P_Ready;
    end

    assign P_RData  = pRData;
    assign D_RData  = dRData;
    assign dbgState = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MemLatency=2 instance plus a
// MemLatency=1 instance sharing the same inputs.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int Dw = 16;
    localparam int Aw = 16;
    localparam logic [1:0] StIdle = 2'(IDLE);

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          P_Req = 1'b0, P_Write = 1'b0;
    logic [Aw-1:0] P_Addr = '0;
    logic [Dw-1:0] P_WData = '0;
    logic          D_Req = 1'b0, D_Write = 1'b0;
    logic [Aw-1:0] D_Addr = '0;
    logic [Dw-1:0] D_WData = '0;
    logic [Dw-1:0] MemOutput = '0;

    logic          P_Ready, P_Stall, D_Ready, MemRead, MemWrite;
    logic [Dw-1:0] P_RData, D_RData, MemData;
    logic [Aw-1:0] MemAddr;
    logic [1:0]    dbgState;

    logic          p1Ready, p1Stall, d1Ready, memRead1, memWrite1;
    logic [Dw-1:0] p1RData, d1RData, memData1;
    logic [Aw-1:0] memAddr1;
    logic [1:0]    dbgState1;

    int checks = 0;
    int errors = 0;
    int bothHigh = 0;

    logic [1:0] expQ[$];

    mem_port_arbiter #(.DataWidth(Dw), .AddrWidth(Aw), .MemLatency(2)) dut (
        .CLK(CLK), .RST(RST),
        .P_Req(P_Req), .P_Write(P_Write), .P_Addr(P_Addr), .P_WData(P_WData),
        .P_Ready(P_Ready), .P_RData(P_RData), .P_Stall(P_Stall),
        .D_Req(D_Req), .D_Write(D_Write), .D_Addr(D_Addr), .D_WData(D_WData),
        .D_Ready(D_Ready), .D_RData(D_RData),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemAddr(MemAddr), .MemData(MemData),
        .MemOutput(MemOutput), .dbgState(dbgState)
    );

    mem_port_arbiter #(.DataWidth(Dw), .AddrWidth(Aw), .MemLatency(1)) dut1 (
        .CLK(CLK), .RST(RST),
        .P_Req(P_Req), .P_Write(P_Write), .P_Addr(P_Addr), .P_WData(P_WData),
        .P_Ready(p1Ready), .P_RData(p1RData), .P_Stall(p1Stall),
        .D_Req(D_Req), .D_Write(D_Write), .D_Addr(D_Addr), .D_WData(D_WData),
        .D_Ready(d1Ready), .D_RData(d1RData),
        .MemRead(memRead1), .MemWrite(memWrite1), .MemAddr(memAddr1), .MemData(memData1),
        .MemOutput(MemOutput), .dbgState(dbgState1)
    );

    // Clock
    always #5 CLK = ~CLK;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Strobe exclusivity monitor for both instances
    always @(negedge CLK) begin
        if ((MemRead && MemWrite) || (memRead1 && memWrite1)) bothHigh++;
    end

    // Driver: quiet inputs, pulse reset, release on a falling edge
    task automatic doReset();
        RST = 1'b0;
        P_Req = 1'b0; P_Write = 1'b0; P_Addr = '0; P_WData = '0;
        D_Req = 1'b0; D_Write = 1'b0; D_Addr = '0; D_WData = '0;
        MemOutput = '0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if ({MemRead, MemWrite, P_Ready, D_Ready} !== 4'b0000) begin
            errors++; $display("FAIL reset_strobes: got %b expected 0000", {MemRead, MemWrite, P_Ready, D_Ready});
        end
        checks++;
        if ({MemAddr, MemData, P_RData, D_RData} !== 64'h0) begin
            errors++; $display("FAIL reset_buses: got %h expected 0", {MemAddr, MemData, P_RData, D_RData});
        end
        checks++;
        if (dbgState !== StIdle || dbgState1 !== StIdle) begin
            errors++; $display("FAIL reset_state: got %0d/%0d expected 0/0", dbgState, dbgState1);
        end
        doReset();
    endtask

    task automatic test_p_read();
        doReset();
        P_Req = 1'b1; P_Write = 1'b0; P_Addr = 16'h0010; MemOutput = 16'hBEEF;
        #1;
        checks++;
        if (P_Stall !== 1'b1) begin errors++; $display("FAIL p_read_stall0: got %b expected 1", P_Stall); end
        for (int k = 1; k <= 3; k++) begin
            @(negedge CLK);
            if (k < 3) begin
                checks++;
                if ({MemRead, MemWrite, P_Ready, P_Stall} !== 4'b1001 || MemAddr !== 16'h0010) begin
                    errors++;
                    $display("FAIL p_read_access%0d: got rd/wr/rdy/stall=%b addr=%h expected 1001 addr=0010",
                             k, {MemRead, MemWrite, P_Ready, P_Stall}, MemAddr);
                end
            end else begin
                checks++;
                if ({MemRead, P_Ready, P_Stall} !== 3'b010) begin
                    errors++; $display("FAIL p_read_done: got rd/rdy/stall=%b expected 010", {MemRead, P_Ready, P_Stall});
                end
                checks++;
                if (P_RData !== 16'hBEEF) begin errors++; $display("FAIL p_read_data: got %h expected beef", P_RData); end
            end
        end
        P_Req = 1'b0;
        @(negedge CLK);
        checks++;
        if (P_Ready !== 1'b0 || P_RData !== 16'hBEEF) begin
            errors++; $display("FAIL p_read_after: got rdy=%b data=%h expected 0 beef", P_Ready, P_RData);
        end
    endtask

    task automatic test_d_write();
        int c;
        doReset();
        D_Req = 1'b1; D_Write = 1'b0; D_Addr = 16'h0008; MemOutput = 16'h5A5A;
        for (c = 1; c <= 10; c++) begin
            @(negedge CLK);
            if (D_Ready) break;
        end
        checks++;
        if (c != 3 || D_RData !== 16'h5A5A) begin
            errors++; $display("FAIL d_read_pre: got cycles=%0d data=%h expected 3 5a5a", c, D_RData);
        end
        D_Req = 1'b0;
        @(negedge CLK);
        D_Req = 1'b1; D_Write = 1'b1; D_Addr = 16'h0004; D_WData = 16'h1234; MemOutput = 16'hFFFF;
        for (int k = 1; k <= 3; k++) begin
            @(negedge CLK);
            if (k < 3) begin
                checks++;
                if ({MemWrite, MemRead, D_Ready} !== 3'b100 || MemData !== 16'h1234 || MemAddr !== 16'h0004) begin
                    errors++;
                    $display("FAIL d_write_access%0d: got wr/rd/rdy=%b data=%h addr=%h expected 100 1234 0004",
                             k, {MemWrite, MemRead, D_Ready}, MemData, MemAddr);
                end
            end else begin
                checks++;
                if ({MemWrite, D_Ready, P_Ready} !== 3'b010) begin
                    errors++; $display("FAIL d_write_done: got wr/drdy/prdy=%b expected 010", {MemWrite, D_Ready, P_Ready});
                end
                checks++;
                if (D_RData !== 16'h5A5A) begin errors++; $display("FAIL d_write_rdata: got %h expected 5a5a", D_RData); end
            end
        end
        D_Req = 1'b0; D_Write = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_back_to_back();
        int seen;
        int idleCnt;
        logic [1:0] rdy;
        logic [1:0] exp;
        doReset();
        P_Req = 1'b1; D_Req = 1'b1; P_Addr = 16'h0040; D_Addr = 16'h0050; MemOutput = 16'h1111;
        expQ = {2'b01, 2'b10, 2'b01, 2'b10};
        seen = 0;
        idleCnt = 0;
        for (int c = 0; c < 40 && seen < 4; c++) begin
            @(negedge CLK);
            rdy = {D_Ready, P_Ready};
            if (rdy != 2'b00) begin
                exp = expQ.pop_front();
                checks++;
                if (rdy !== exp) begin errors++; $display("FAIL b2b_grant%0d: got %b expected %b", seen, rdy, exp); end
                if (seen > 0) begin
                    checks++;
                    if (idleCnt != 1) begin errors++; $display("FAIL b2b_idle%0d: got %0d expected 1", seen, idleCnt); end
                end
                idleCnt = 0;
                seen++;
            end else if (dbgState == StIdle) begin
                idleCnt++;
            end
        end
        checks++;
        if (seen != 4) begin errors++; $display("FAIL b2b_timeout: got %0d pulses expected 4", seen); end
        P_Req = 1'b0; D_Req = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        int c;
        doReset();
        P_Req = 1'b1; P_Write = 1'b0; P_Addr = 16'h0020; MemOutput = 16'hCAFE;
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (MemRead !== 1'b1) begin errors++; $display("FAIL rstmid_access2: got %b expected 1", MemRead); end
        RST = 1'b0;
        #1;
        checks++;
        if ({MemRead, MemWrite} !== 2'b00 || MemAddr !== 16'h0 || dbgState !== StIdle) begin
            errors++;
            $display("FAIL rstmid_drop: got rd/wr=%b addr=%h state=%0d expected 00 0000 0",
                     {MemRead, MemWrite}, MemAddr, dbgState);
        end
        @(negedge CLK);
        checks++;
        if (P_Ready !== 1'b0 || P_RData !== 16'h0) begin
            errors++; $display("FAIL rstmid_lost: got rdy=%b data=%h expected 0 0000", P_Ready, P_RData);
        end
        RST = 1'b1;
        for (c = 1; c <= 10; c++) begin
            @(negedge CLK);
            if (P_Ready) break;
        end
        checks++;
        if (c != 3 || P_RData !== 16'hCAFE) begin
            errors++; $display("FAIL rstmid_regrant: got cycles=%0d data=%h expected 3 cafe", c, P_RData);
        end
        P_Req = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_latency1();
        doReset();
        P_Req = 1'b1; P_Write = 1'b0; P_Addr = 16'h0030; MemOutput = 16'h0F0F;
        @(negedge CLK);
        checks++;
        if ({memRead1, memWrite1, p1Ready} !== 3'b100 || memAddr1 !== 16'h0030) begin
            errors++; $display("FAIL lat1_access: got rd/wr/rdy=%b addr=%h expected 100 0030", {memRead1, memWrite1, p1Ready}, memAddr1);
        end
        P_Req = 1'b0;
        @(negedge CLK);
        checks++;
        if ({p1Ready, memRead1} !== 2'b10 || p1RData !== 16'h0F0F) begin
            errors++; $display("FAIL lat1_done: got rdy/rd=%b data=%h expected 10 0f0f", {p1Ready, memRead1}, p1RData);
        end
        @(negedge CLK);
        checks++;
        if (p1Ready !== 1'b0) begin errors++; $display("FAIL lat1_pulse: got %b expected 0", p1Ready); end
        checks++;
        if (P_Ready !== 1'b1 || P_RData !== 16'h0F0F) begin
            errors++; $display("FAIL lat2_dropreq: got rdy=%b data=%h expected 1 0f0f", P_Ready, P_RData);
        end
        @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_p_read();
        test_d_write();
        test_back_to_back();
        test_reset_mid();
        test_latency1();
        checks++;
        if (bothHigh != 0) begin errors++; $display("FAIL strobe_exclusive: got %0d cycles expected 0", bothHigh); end
        $display("%0d/%0d checks passed", checks - errors, checks);
        $finish;
    end

endmodule
